fod_dsm_mash: RTL and testbench

- Parametrised successor of the FOD divider-control delta-sigma modulator.
- Converts a fractional FCW into a per-cycle MMD divide word plus a signed accumulated phase error that drives DTC compensation.
- Noise-shaping order (MASH 1 / 1-1 / 1-1-1) is selectable at run time.
- Divide word is saturated to the legal MMD range.
- FCW/order updates go through a valid/ready shadow-register handshake so changes land glitch-free on an EN cycle.

---
 rtl/fod_pkg.sv | 28 ++
 rtl/fod_acc_stage.sv | 33 +++
 rtl/fod_dsm_mash.sv | 181 ++++++++++++++++++
 tb/tb_fod_dsm_mash.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fod_pkg.sv
// Shared constants and types for the FOD MASH divider-control modulator.
package fod_pkg;

    localparam int unsigned FOD_WI      = 6;
    localparam int unsigned FOD_WF      = 16;
    localparam int unsigned FOD_MMD_MIN = 4;
    localparam int unsigned FOD_MMD_MAX = 63;

    // x^15 + x^14 + 1 Fibonacci LFSR used only by the dither build
    localparam logic [14:0] LFSR_SEED = 15'h0001;
    localparam logic [14:0] LFSR_TAPS = 15'h6000;

    typedef enum logic [1:0] {
        ORD1 = 2'd1,
        ORD2 = 2'd2,
        ORD3 = 2'd3
    } ord_t;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } fsm_t;

    function automatic ord_t ord_decode(input logic [1:0] ord);
        return (ord == 2'd0) ? ORD1 : ord_t'(ord);
    endfunction

endpackage

// File: rtl/fod_acc_stage.sv
// One MASH accumulator stage: registered WF-bit sum, combinational next sum and carry.
module fod_acc_stage
#(
    parameter int unsigned WF = 16
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    input  logic [WF-1:0] add,
    input  logic          cin,
    output logic [WF-1:0] sum,
    output logic          carry
);

    logic [WF-1:0] acc_q;
    logic [WF-1:0] base;

    // clr zeroes the stored value before it is used in the same cycle
    always_comb begin
        base         = clr ? '0 : acc_q;
        {carry, sum} = {1'b0, base} + {1'b0, add} + {{WF{1'b0}}, cin};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= sum;
        end
    end

endmodule

// File: rtl/fod_dsm_mash.sv
// MASH 1 / 1-1 / 1-1-1 divider-control modulator with saturated MMD word and phase error.
// Optional LFSR dither on the stage-1 LSB when FOD_DSM_DITHER_EN is defined.
module fod_dsm_mash
    import fod_pkg::*;
#(
    parameter int unsigned WI      = FOD_WI,
    parameter int unsigned WF      = FOD_WF,
    parameter int unsigned PW      = WF + 3,
    parameter int unsigned MMD_MIN = FOD_MMD_MIN,
    parameter int unsigned MMD_MAX = FOD_MMD_MAX
)(
    input  logic          CLK,
    input  logic          NRST,
    input  logic          EN,
    input  logic [WI-1:0] FCW_I,
    input  logic [WF-1:0] FCW_F,
    input  logic [1:0]    ORDER,
    input  logic          FCW_VALID,
    output logic          FCW_READY,
    output logic [WI-1:0] MMD_DCW,
    output logic [PW-1:0] PHE,
    output logic          OVF
);

    localparam logic signed [WI+1:0] N_MIN = (WI+2)'(MMD_MIN);
    localparam logic signed [WI+1:0] N_MAX = (WI+2)'(MMD_MAX);

    fsm_t          state_q, state_d;
    logic          capture, copy;
    logic [WI-1:0] sh_i_q, act_i_q, cur_i;
    logic [WF-1:0] sh_f_q, act_f_q, cur_f;
    ord_t          sh_ord_q, act_ord_q, cur_ord;
    logic          clr_hi, use2, use3;
    logic          dith;
    logic [WF-1:0] s1n, s2n;
    logic          c1, c2, c3;
    logic          c2d_q, c3d1_q, c3d2_q;
    logic          c2d, c3d1, c3d2;
    logic [3:0]    y;
    logic signed [WI+1:0] n_s;
    logic [WI-1:0] mmd_d;
    logic          ovf_d;
    logic [WF:0]   f_ext;
    logic [PW-1:0] y_ext, phe_d;

    always_comb begin
        state_d   = state_q;
        FCW_READY = 1'b0;
        capture   = 1'b0;
        copy      = 1'b0;
        case (state_q)
            RUN: begin
                FCW_READY = 1'b1;
                if (FCW_VALID) begin
                    capture = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (EN) begin
                    copy    = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q   <= RUN;
            sh_i_q    <= '0;
            sh_f_q    <= '0;
            sh_ord_q  <= ORD1;
            act_i_q   <= WI'(MMD_MIN);
            act_f_q   <= '0;
            act_ord_q <= ORD1;
        end else begin
            state_q <= state_d;
            if (capture) begin
                sh_i_q   <= FCW_I;
                sh_f_q   <= FCW_F;
                sh_ord_q <= ord_decode(ORDER);
            end
            if (copy) begin
                act_i_q   <= sh_i_q;
                act_f_q   <= sh_f_q;
                act_ord_q <= sh_ord_q;
            end
        end
    end

    // The copy cycle already steps with the shadow values
    always_comb begin
        cur_i   = copy ? sh_i_q   : act_i_q;
        cur_f   = copy ? sh_f_q   : act_f_q;
        cur_ord = copy ? sh_ord_q : act_ord_q;
        clr_hi  = copy && (sh_ord_q != act_ord_q);
        use2    = (cur_ord != ORD1);
        use3    = (cur_ord == ORD3);
    end

`ifdef FOD_DSM_DITHER_EN
    logic [14:0] lfsr_q;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            lfsr_q <= LFSR_SEED;
        end else if (EN) begin
            lfsr_q <= {lfsr_q[13:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign dith = lfsr_q[0];
`else
    assign dith = 1'b0;
`endif

    fod_acc_stage #(.WF(WF)) u_stage1 (
        .clk(CLK), .rst_n(NRST), .en(EN), .clr(1'b0),
        .add(cur_f), .cin(dith), .sum(s1n), .carry(c1)
    );

    // Unused stages are held cleared so their sums and carries stay at 0
    fod_acc_stage #(.WF(WF)) u_stage2 (
        .clk(CLK), .rst_n(NRST), .en(EN), .clr(clr_hi | ~use2),
        .add(use2 ? s1n : '0), .cin(1'b0), .sum(s2n), .carry(c2)
    );

    fod_acc_stage #(.WF(WF)) u_stage3 (
        .clk(CLK), .rst_n(NRST), .en(EN), .clr(clr_hi | ~use3),
        .add(use3 ? s2n : '0), .cin(1'b0), .sum(), .carry(c3)
    );

    always_comb begin
        c2d   = clr_hi ? 1'b0 : c2d_q;
        c3d1  = clr_hi ? 1'b0 : c3d1_q;
        c3d2  = clr_hi ? 1'b0 : c3d2_q;
        case (cur_ord)
            ORD1:    y = {3'b000, c1};
            ORD2:    y = {3'b000, c1} + {3'b000, c2} - {3'b000, c2d};
            default: y = {3'b000, c1} + {3'b000, c2} - {3'b000, c2d}
                       + {3'b000, c3} - {2'b00, c3d1, 1'b0} + {3'b000, c3d2};
        endcase

        n_s = $signed({2'b00, cur_i}) + $signed({{(WI-2){y[3]}}, y});
        if (n_s < N_MIN) begin
            mmd_d = WI'(MMD_MIN);
            ovf_d = 1'b1;
        end else if (n_s > N_MAX) begin
            mmd_d = WI'(MMD_MAX);
            ovf_d = 1'b1;
        end else begin
            mmd_d = n_s[WI-1:0];
            ovf_d = 1'b0;
        end

        f_ext = {1'b0, cur_f} + {{WF{1'b0}}, dith};
        y_ext = {{(PW-4){y[3]}}, y};
        phe_d = PHE + {{(PW-WF-1){1'b0}}, f_ext} - (y_ext << WF);
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            c2d_q   <= 1'b0;
            c3d1_q  <= 1'b0;
            c3d2_q  <= 1'b0;
            MMD_DCW <= WI'(MMD_MIN);
            PHE     <= '0;
            OVF     <= 1'b0;
        end else if (EN) begin
            c2d_q   <= c2;
            c3d1_q  <= c3;
            c3d2_q  <= c3d1;
            MMD_DCW <= mmd_d;
            PHE     <= phe_d;
            OVF     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_fod_dsm_mash.sv
// Randomised bench for fod_dsm_mash against an integer-arithmetic reference model.
module tb_fod_dsm_mash;

    localparam int     WI = 6;
    localparam int     WF = 16;
    localparam int     PW = 19;
    localparam longint M  = 64'd65536;
    localparam longint PM = 64'd524288;

    logic          CLK = 1'b0;
    logic          NRST;
    logic          EN;
    logic [WI-1:0] FCW_I;
    logic [WF-1:0] FCW_F;
    logic [1:0]    ORDER;
    logic          FCW_VALID;
    logic          FCW_READY;
    logic [WI-1:0] MMD_DCW;
    logic [PW-1:0] PHE;
    logic          OVF;

    fod_dsm_mash #(.WI(WI), .WF(WF), .PW(PW), .MMD_MIN(4), .MMD_MAX(63)) dut (
        .CLK(CLK), .NRST(NRST), .EN(EN), .FCW_I(FCW_I), .FCW_F(FCW_F),
        .ORDER(ORDER), .FCW_VALID(FCW_VALID), .FCW_READY(FCW_READY),
        .MMD_DCW(MMD_DCW), .PHE(PHE), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model state
    int     m_act_i, m_act_f, m_ord, m_sh_i, m_sh_f, m_sh_ord;
    int     m_c2d, m_c3d1, m_c3d2, m_mmd, m_ovf;
    bit     m_pend;
    longint m_s1, m_s2, m_s3, m_phe;

    // Statistics over DUT outputs for bound checks
    bit     st_on;
    longint st_sum, st_min, st_max, st_phe_min, st_phe_max;
    int     st_ovf;

    task automatic model_reset();
        m_act_i = 4; m_act_f = 0; m_ord = 1;
        m_sh_i = 0; m_sh_f = 0; m_sh_ord = 1; m_pend = 0;
        m_s1 = 0; m_s2 = 0; m_s3 = 0;
        m_c2d = 0; m_c3d1 = 0; m_c3d2 = 0;
        m_mmd = 4; m_ovf = 0; m_phe = 0;
    endtask

    task automatic model_step(input bit en, input bit valid, input int fi, input int ff, input int ord);
        bit     cap, cp;
        longint f, y, n;
        int     c1, c2, c3;
        cap = valid && !m_pend;
        cp  = en && m_pend;
        if (cp) begin
            if (m_sh_ord != m_ord) begin
                m_s2 = 0; m_s3 = 0; m_c2d = 0; m_c3d1 = 0; m_c3d2 = 0;
            end
            m_act_i = m_sh_i; m_act_f = m_sh_f; m_ord = m_sh_ord;
            m_pend  = 0;
        end
        if (cap) begin
            m_sh_i = fi; m_sh_f = ff; m_sh_ord = (ord == 0) ? 1 : ord;
            m_pend = 1;
        end
        if (en) begin
            f    = m_act_f;
            m_s1 = m_s1 + f;
            c1   = int'(m_s1 / M);
            m_s1 = m_s1 % M;
            c2 = 0; c3 = 0;
            if (m_ord >= 2) begin
                m_s2 = m_s2 + m_s1; c2 = int'(m_s2 / M); m_s2 = m_s2 % M;
            end else m_s2 = 0;
            if (m_ord == 3) begin
                m_s3 = m_s3 + m_s2; c3 = int'(m_s3 / M); m_s3 = m_s3 % M;
            end else m_s3 = 0;
            case (m_ord)
                1:       y = c1;
                2:       y = c1 + c2 - m_c2d;
                default: y = c1 + c2 - m_c2d + c3 - 2 * m_c3d1 + m_c3d2;
            endcase
            n = m_act_i + y;
            if (n < 4)       begin m_mmd = 4;       m_ovf = 1; end
            else if (n > 63) begin m_mmd = 63;      m_ovf = 1; end
            else             begin m_mmd = int'(n); m_ovf = 0; end
            m_phe = m_phe + f - y * M;
            m_phe = ((m_phe % PM) + PM) % PM;
            if (m_phe >= PM / 2) m_phe = m_phe - PM;
            m_c3d2 = m_c3d1; m_c3d1 = c3; m_c2d = c2;
        end
    endtask

    function automatic longint phe_now();
        return longint'($signed(PHE));
    endfunction

    // Called at a falling edge: drive, check READY, predict, clock, check outputs
    task automatic cycle(input bit en, input bit valid, input int fi, input int ff, input int ord);
        logic [31:0] vi, vf, vo;
        vi = fi; vf = ff; vo = ord;
        EN = en; FCW_VALID = valid;
        FCW_I = vi[WI-1:0]; FCW_F = vf[WF-1:0]; ORDER = vo[1:0];
        #1;
        check("ready", FCW_READY, longint'(!m_pend));
        model_step(en, valid, fi, ff, ord);
        @(posedge CLK);
        @(negedge CLK);
        check("mmd", MMD_DCW, m_mmd);
        check("phe", phe_now(), m_phe);
        check("ovf", OVF, m_ovf);
        if (st_on) begin
            st_sum = st_sum + MMD_DCW;
            if (MMD_DCW < st_min) st_min = MMD_DCW;
            if (MMD_DCW > st_max) st_max = MMD_DCW;
            if (phe_now() < st_phe_min) st_phe_min = phe_now();
            if (phe_now() > st_phe_max) st_phe_max = phe_now();
            if (OVF) st_ovf++;
        end
    endtask

    task automatic stats_clear();
        st_sum = 0; st_min = 1000; st_max = -1;
        st_phe_min = PM; st_phe_max = -PM; st_ovf = 0;
    endtask

    int o1_mmd [8] = '{8, 8, 8, 9, 8, 8, 8, 9};
    int o1_phe [4] = '{'h4000, 'h8000, 'hC000, 0};
    int ri, rf;

    initial begin
        st_on = 0;
        stats_clear();
        NRST = 1'b0; EN = 1'b0; FCW_VALID = 1'b0;
        FCW_I = '0; FCW_F = '0; ORDER = '0;
        model_reset();
        repeat (3) @(negedge CLK);
        check("rst_mmd", MMD_DCW, 4);
        check("rst_phe", phe_now(), 0);
        check("rst_ovf", OVF, 0);
        check("rst_ready", FCW_READY, 1);
        NRST = 1'b1;
        @(negedge CLK);

        // Order 1, 8 + 0.25
        cycle(1, 1, 8, 'h4000, 1);
        check("o1_old_fcw", MMD_DCW, 4);
        for (int k = 0; k < 8; k++) begin
            cycle(1, 0, 8, 'h4000, 1);
            check("o1_pattern_mmd", MMD_DCW, o1_mmd[k]);
            check("o1_pattern_phe", phe_now(), o1_phe[k % 4]);
        end

        // Order 2, 10 + 0.5 over 1024 cycles
        cycle(1, 1, 10, 'h8000, 2);
        stats_clear(); st_on = 1;
        for (int k = 0; k < 1024; k++) cycle(1, 0, 10, 'h8000, 2);
        st_on = 0;
        check("o2_min_ge_9", longint'(st_min >= 9), 1);
        check("o2_max_le_12", longint'(st_max <= 12), 1);
        check("o2_mean_10p5", longint'(st_sum >= 10751 && st_sum <= 10753), 1);
        check("o2_phe_range", longint'(st_phe_min >= -131072 && st_phe_max < 131072), 1);

        // Order 3 at the top of the MMD range
        cycle(1, 1, 63, 'h8000, 3);
        stats_clear(); st_on = 1;
        for (int k = 0; k < 200; k++) cycle(1, 0, 63, 'h8000, 3);
        st_on = 0;
        check("o3_max_le_63", longint'(st_max <= 63), 1);
        check("o3_ovf_seen", longint'(st_ovf > 0), 1);

        // Handshake with EN low, then copy and immediate second request
        for (int k = 0; k < 3; k++) cycle(0, 1, 20, 'h1234, 2);
        check("hs_ready_low", FCW_READY, 0);
        cycle(1, 1, 30, 'h5555, 1);
        check("hs_ready_back", FCW_READY, 1);
        cycle(1, 1, 30, 'h5555, 1);
        for (int k = 0; k < 6; k++) cycle(1, 0, 0, 0, 0);

        // Order change 1 -> 3 mid-run with random FCW
        ri = $urandom_range(10, 50); rf = $urandom_range(1, 65535);
        cycle(1, 1, ri, rf, 1);
        for (int k = 0; k < 20; k++) cycle(1, 0, 0, 0, 0);
        rf = $urandom_range(1, 65535);
        cycle(1, 1, ri, rf, 3);
        for (int k = 0; k < 30; k++) cycle(1, 0, 0, 0, 0);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) == 0),
                  $urandom_range(0, 63), $urandom_range(0, 65535), $urandom_range(0, 3));
        end

        // Reset while a request is pending and EN toggles
        if (m_pend) cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 40, 'h2222, 3);
        check("pend_ready", FCW_READY, 0);
        EN = 1'b1; FCW_VALID = 1'b0;
        #2 NRST = 1'b0;
        #1;
        check("midrst_mmd", MMD_DCW, 4);
        check("midrst_phe", phe_now(), 0);
        check("midrst_ovf", OVF, 0);
        check("midrst_ready", FCW_READY, 1);
        EN = 1'b0;
        @(negedge CLK);
        EN = 1'b1;
        @(negedge CLK);
        NRST = 1'b1;
        model_reset();
        cycle(1, 0, 0, 0, 0);
        check("post_rst_mmd", MMD_DCW, 4);
        check("post_rst_phe", phe_now(), 0);
        cycle(1, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
